// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of stage-register fields going into the hazard controller and the
// pipeline-register controls and status it drives back to the datapath.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_is_mul;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [4:0]  ex_dest;
    logic        mem_reg_write;
    logic [4:0]  mem_dest;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic        br_taken;
    logic        mul_busy;
    logic        mul_done;

    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        mul_start;
    logic        mul_err;
    logic [15:0] stall_count;
    logic [1:0]  state;

    // Datapath side: supplies stage fields, consumes controls.
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mul,
        output ex_rs, ex_rt, ex_mem_read, ex_reg_write, ex_dest,
        output mem_reg_write, mem_dest, wb_reg_write, wb_dest,
        output br_taken, mul_busy, mul_done,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
        input  fwd_a, fwd_b, mul_start, mul_err, stall_count, state
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mul,
        input  ex_rs, ex_rt, ex_mem_read, ex_reg_write, ex_dest,
        input  mem_reg_write, mem_dest, wb_reg_write, wb_dest,
        input  br_taken, mul_busy, mul_done,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
        output fwd_a, fwd_b, mul_start, mul_err, stall_count, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: forwarding,
// load-use stalls, branch flushes and multiply-unit handshaking.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MUL_TIMEOUT  = 64
) (
    input logic               clock,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FLUSH    = 2'b01,
        MUL_WAIT = 2'b10
    } state_t;

    localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TMO_LAST    = 8'(MUL_TIMEOUT - 1);
    localparam state_t     BRANCH_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  flush_cnt_q;
    logic [3:0]  flush_cnt_d;
    logic [7:0]  tmo_cnt_q;
    logic [7:0]  tmo_cnt_d;
    logic        mul_ack_q;
    logic        mul_ack_d;
    logic        mul_err_q;
    logic        mul_err_d;
    logic [15:0] stall_cnt_q;

    logic        lu;
    logic        take_branch;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_flush;
    logic        mul_start;
    logic        unused_ok;

    // EX/MEM has the younger result, so it wins over MEM/WB; $0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd,
        input logic [4:0] src
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            return 2'b10;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign bus.fwd_a = fwd_sel(bus.mem_reg_write, bus.mem_dest,
                               bus.wb_reg_write, bus.wb_dest, bus.ex_rs);
    assign bus.fwd_b = fwd_sel(bus.mem_reg_write, bus.mem_dest,
                               bus.wb_reg_write, bus.wb_dest, bus.ex_rt);

    assign lu = bus.ex_mem_read && (bus.ex_dest != 5'd0) &&
                ((bus.id_uses_rs && (bus.id_rs == bus.ex_dest)) ||
                 (bus.id_uses_rt && (bus.id_rt == bus.ex_dest)));

    // A branch already being flushed cannot be overtaken by another one.
    assign take_branch = bus.br_taken && (state_q != FLUSH);

    assign unused_ok = bus.ex_reg_write;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        mul_ack_d    = mul_ack_q;
        mul_err_d    = mul_err_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        mul_start    = 1'b0;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (take_branch) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = BRANCH_NEXT;
            flush_cnt_d  = FLUSH_LOAD;
        end else begin
            case (state_q)
                RUN: begin
                    if (lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (bus.id_is_mul && !mul_ack_q && !bus.mul_busy) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        mul_start    = 1'b1;
                        state_d      = MUL_WAIT;
                        tmo_cnt_d    = 8'd0;
                    end
                end
                FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    ex_mem_flush = 1'b1;
                    flush_cnt_d  = flush_cnt_q - 4'd1;
                    if (flush_cnt_q <= 4'd1) begin
                        state_d = RUN;
                    end
                end
                MUL_WAIT: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    tmo_cnt_d    = tmo_cnt_q + 8'd1;
                    // A done arriving on the expiry cycle still counts as success.
                    if (bus.mul_done) begin
                        mul_ack_d = 1'b1;
                        state_d   = RUN;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        mul_err_d = 1'b1;
                        mul_ack_d = 1'b0;
                        state_d   = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        // Once the multiply leaves ID the acknowledge has done its job.
        if (if_id_write) begin
            mul_ack_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
            tmo_cnt_q   <= 8'd0;
            mul_ack_q   <= 1'b0;
            mul_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mul_ack_q   <= mul_ack_d;
            mul_err_q   <= mul_err_d;
            if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.mul_start    = mul_start;
    assign bus.mul_err      = mul_err_q;
    assign bus.stall_count  = stall_cnt_q;
    assign bus.state        = state_q;

    a_start_single: assert property (@(posedge clock) disable iff (reset)
        bus.mul_start |=> !bus.mul_start);
    a_state_legal: assert property (@(posedge clock) disable iff (reset)
        state_q != 2'b11);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-level
// behavioural model of the pipeline hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int MUL_TIMEOUT  = 12;

    typedef struct {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       is_mul;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic       ex_mem_read;
        logic       ex_reg_write;
        logic [4:0] ex_dest;
        logic       mem_reg_write;
        logic [4:0] mem_dest;
        logic       wb_reg_write;
        logic [4:0] wb_dest;
        logic       br;
        logic       busy;
        logic       done;
    } stim_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .MUL_TIMEOUT (MUL_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int check_count = 0;
    int pass_count  = 0;

    // Model: remaining extra flush cycles, multiply-in-flight bookkeeping.
    int m_flush_left = 0;
    int m_wait       = 0;
    int m_stalls     = 0;
    bit m_in_mul     = 0;
    bit m_ack        = 0;
    bit m_err        = 0;

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst = 1'b0;           s.id_rs = 5'd0;         s.id_rt = 5'd0;
        s.uses_rs = 1'b0;       s.uses_rt = 1'b0;       s.is_mul = 1'b0;
        s.ex_rs = 5'd0;         s.ex_rt = 5'd0;         s.ex_mem_read = 1'b0;
        s.ex_reg_write = 1'b0;  s.ex_dest = 5'd0;       s.mem_reg_write = 1'b0;
        s.mem_dest = 5'd0;      s.wb_reg_write = 1'b0;  s.wb_dest = 5'd0;
        s.br = 1'b0;            s.busy = 1'b0;          s.done = 1'b0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst           = ($urandom_range(0, 149) == 0);
        s.id_rs         = 5'($urandom_range(0, 3));
        s.id_rt         = 5'($urandom_range(0, 3));
        s.uses_rs       = 1'($urandom_range(0, 1));
        s.uses_rt       = 1'($urandom_range(0, 1));
        s.is_mul        = ($urandom_range(0, 3) == 0);
        s.ex_rs         = 5'($urandom_range(0, 3));
        s.ex_rt         = 5'($urandom_range(0, 3));
        s.ex_mem_read   = ($urandom_range(0, 2) == 0);
        s.ex_reg_write  = 1'($urandom_range(0, 1));
        s.ex_dest       = 5'($urandom_range(0, 3));
        s.mem_reg_write = 1'($urandom_range(0, 1));
        s.mem_dest      = 5'($urandom_range(0, 3));
        s.wb_reg_write  = 1'($urandom_range(0, 1));
        s.wb_dest       = 5'($urandom_range(0, 3));
        s.br            = ($urandom_range(0, 11) == 0);
        s.busy          = ($urandom_range(0, 7) == 0);
        s.done          = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    function automatic logic [1:0] model_fwd(input stim_t s, input logic [4:0] src);
        if (s.mem_reg_write && s.mem_dest != 0 && s.mem_dest == src) return 2'b10;
        if (s.wb_reg_write && s.wb_dest != 0 && s.wb_dest == src) return 2'b01;
        return 2'b00;
    endfunction

    // Drive one cycle, compare every output to the model, then advance the model.
    task automatic applyStimulus(input stim_t s);
        bit lu, flushing, e_pc, e_bub, e_fl, e_start;
        int e_state;
        @(negedge clock);
        reset             = s.rst;
        bus.id_rs         = s.id_rs;         bus.id_rt        = s.id_rt;
        bus.id_uses_rs    = s.uses_rs;       bus.id_uses_rt   = s.uses_rt;
        bus.id_is_mul     = s.is_mul;        bus.ex_rs        = s.ex_rs;
        bus.ex_rt         = s.ex_rt;         bus.ex_mem_read  = s.ex_mem_read;
        bus.ex_reg_write  = s.ex_reg_write;  bus.ex_dest      = s.ex_dest;
        bus.mem_reg_write = s.mem_reg_write; bus.mem_dest     = s.mem_dest;
        bus.wb_reg_write  = s.wb_reg_write;  bus.wb_dest      = s.wb_dest;
        bus.br_taken      = s.br;            bus.mul_busy     = s.busy;
        bus.mul_done      = s.done;
        #1;
        lu = s.ex_mem_read && s.ex_dest != 0 &&
             ((s.uses_rs && s.id_rs == s.ex_dest) || (s.uses_rt && s.id_rt == s.ex_dest));
        flushing = (m_flush_left > 0);
        e_pc = 1; e_bub = 0; e_fl = 0; e_start = 0;
        if (s.rst) begin
            e_pc = 0; e_bub = 1; e_fl = 1;
        end else if (flushing || s.br) begin
            e_bub = 1; e_fl = 1;
        end else if (m_in_mul || lu) begin
            e_pc = 0; e_bub = 1;
        end else if (s.is_mul && !m_ack && !s.busy) begin
            e_pc = 0; e_bub = 1; e_start = 1;
        end
        e_state = flushing ? 1 : (m_in_mul ? 2 : 0);

        checkOutput("pc_write",     16'(bus.pc_write),     16'(e_pc));
        checkOutput("if_id_write",  16'(bus.if_id_write),  16'(e_pc));
        checkOutput("if_id_flush",  16'(bus.if_id_flush),  16'(e_fl));
        checkOutput("id_ex_bubble", 16'(bus.id_ex_bubble), 16'(e_bub));
        checkOutput("ex_mem_flush", 16'(bus.ex_mem_flush), 16'(e_fl));
        checkOutput("mul_start",    16'(bus.mul_start),    16'(e_start));
        checkOutput("fwd_a",        16'(bus.fwd_a),        16'(model_fwd(s, s.ex_rs)));
        checkOutput("fwd_b",        16'(bus.fwd_b),        16'(model_fwd(s, s.ex_rt)));
        checkOutput("state",        16'(bus.state),        16'(e_state));
        checkOutput("mul_err",      16'(bus.mul_err),      16'(m_err));
        checkOutput("stall_count",  bus.stall_count,       16'(m_stalls));

        @(posedge clock);
        if (s.rst) begin
            m_flush_left = 0; m_wait = 0; m_stalls = 0;
            m_in_mul = 0; m_ack = 0; m_err = 0;
        end else begin
            if (!e_pc && m_stalls < 65535) m_stalls++;
            if (flushing) begin
                m_flush_left--;
            end else if (s.br) begin
                m_flush_left = FLUSH_CYCLES - 1;
                m_in_mul     = 0;
            end else if (m_in_mul) begin
                m_wait++;
                if (s.done) begin
                    m_in_mul = 0; m_ack = 1;
                end else if (m_wait == MUL_TIMEOUT) begin
                    m_in_mul = 0; m_err = 1;
                end
            end else if (e_start) begin
                m_in_mul = 1; m_wait = 0;
            end
            if (e_pc) m_ack = 0;
        end
    endtask

    task automatic doReset();
        stim_t s;
        s = idle_stim();
        s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
    endtask

    initial begin
        stim_t s;

        doReset();

        // Forwarding: EX/MEM beats MEM/WB; $0 never forwards.
        s = idle_stim();
        s.mem_reg_write = 1; s.mem_dest = 5; s.wb_reg_write = 1; s.wb_dest = 5; s.ex_rs = 5;
        applyStimulus(s);
        #1 checkOutput("tp_fwd_a_exmem", 16'(bus.fwd_a), 16'h2);
        s.mem_dest = 0; s.wb_dest = 0; s.ex_rs = 0;
        applyStimulus(s);
        #1 checkOutput("tp_fwd_a_zero", 16'(bus.fwd_a), 16'h0);

        // Load-use: one stall cycle, then the load forwards from EX/MEM.
        doReset();
        s = idle_stim();
        s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_dest = 8; s.uses_rt = 1; s.id_rt = 8;
        applyStimulus(s);
        #1 checkOutput("tp_lu_stalls", bus.stall_count, 16'd1);
        s = idle_stim();
        s.mem_reg_write = 1; s.mem_dest = 8; s.ex_rt = 8;
        applyStimulus(s);
        #1 checkOutput("tp_lu_fwd_b", 16'(bus.fwd_b), 16'h2);
        checkOutput("tp_lu_stalls_hold", bus.stall_count, 16'd1);

        // Branch: two flush cycles, a second branch during FLUSH is ignored.
        doReset();
        s = idle_stim();
        s.br = 1;
        applyStimulus(s);
        #1 checkOutput("tp_br_state_flush", 16'(bus.state), 16'h1);
        applyStimulus(s);
        #1 checkOutput("tp_br_state_run", 16'(bus.state), 16'h0);
        s.br = 0;
        applyStimulus(s);

        // Multiply: start, 10 wait cycles, done; acknowledged op must not restart.
        doReset();
        s = idle_stim();
        s.is_mul = 1;
        applyStimulus(s);
        s.busy = 1;
        for (int i = 0; i < 9; i++) applyStimulus(s);
        s.done = 1;
        applyStimulus(s);
        #1 checkOutput("tp_mul_stalls", bus.stall_count, 16'd11);
        checkOutput("tp_mul_state", 16'(bus.state), 16'h0);
        s.done = 0; s.busy = 0;
        applyStimulus(s);
        s = idle_stim();
        applyStimulus(s);

        // Timeout: no done ever; error is sticky.
        doReset();
        s = idle_stim();
        s.is_mul = 1;
        applyStimulus(s);
        s.is_mul = 0;
        for (int i = 0; i < MUL_TIMEOUT; i++) applyStimulus(s);
        #1 checkOutput("tp_tmo_err", 16'(bus.mul_err), 16'h1);
        for (int i = 0; i < 3; i++) applyStimulus(s);
        #1 checkOutput("tp_tmo_sticky", 16'(bus.mul_err), 16'h1);

        // Done on the expiry cycle wins over the timeout.
        doReset();
        s = idle_stim();
        s.is_mul = 1;
        applyStimulus(s);
        s.is_mul = 0;
        for (int i = 0; i < MUL_TIMEOUT - 1; i++) applyStimulus(s);
        s.done = 1;
        applyStimulus(s);
        #1 checkOutput("tp_done_at_expiry", 16'(bus.mul_err), 16'h0);

        // Branch kills an in-flight multiply; its late done is ignored.
        doReset();
        s = idle_stim();
        s.is_mul = 1;
        applyStimulus(s);
        s.is_mul = 0;
        applyStimulus(s);
        s.br = 1;
        applyStimulus(s);
        s.br = 0; s.done = 1;
        applyStimulus(s);
        s.done = 0;
        applyStimulus(s);

        // Reset in MUL_WAIT, then a stale done.
        doReset();
        s = idle_stim();
        s.is_mul = 1;
        applyStimulus(s);
        s.is_mul = 0;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        s.rst = 1;
        applyStimulus(s);
        #1 checkOutput("tp_rst_state", 16'(bus.state), 16'h0);
        checkOutput("tp_rst_stalls", bus.stall_count, 16'd0);
        checkOutput("tp_rst_err", 16'(bus.mul_err), 16'h0);
        s = idle_stim();
        s.done = 1;
        applyStimulus(s);
        #1 checkOutput("tp_late_done", 16'(bus.state), 16'h0);

        for (int i = 0; i < 2000; i++) applyStimulus(rand_stim());

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
